i2s_tx: RTL and testbench

Serialises 24-bit stereo DAC samples into a standard Philips I2S stream (64 BCLK per frame, 32-bit slots, 24-bit MSB-first data). Sits directly downstream of the DAC sample preparation stage: it accepts its `sample_valid`/`sample_l`/`sample_r` strobe-and-data output, holds one pending frame, and drives BCLK, LRCLK and SDATA pins derived from the system clock. It also flags overrun and underrun so that rate mismatches between the synth and the DAC are visible.

---
 rtl/i2s_tx_if.sv | 15 +
 rtl/i2s_tx.sv | 164 ++++++++++++++++
 tb/tb_i2s_tx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample input bundle for i2s_tx.
// Handshake: strobe-only. sample_valid is high for one clk cycle and qualifies
// sample_l/sample_r in that same cycle. There is no ready: the transmitter
// always accepts, and it reports dropped or missing samples through its
// overrun/underrun pulses.
interface i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] sample_l;
  logic [SAMPLE_WIDTH-1:0] sample_r;

  modport master (output sample_valid, output sample_l, output sample_r);
  modport slave  (input  sample_valid, input  sample_l, input  sample_r);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter. It produces 64 BCLK per frame in two
// 32-bit slots, with MSB-first data delayed by one BCLK after each LRCLK edge.
// One pending stereo sample is held between the producer and the frame loader.
// Build option: define I2S_TX_UNDERRUN_MUTE_EN to send silence on underrun.
// Without it, an underrun repeats the last loaded sample.
// The frame registers keep the loaded sample for the whole frame. SDATA
// indexes into them instead of destroying them by shifting, so the repeat
// path needs no extra copy.
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_DIV     = 2
) (
  input  logic        clk,
  input  logic        reset,
  i2s_tx_if.slave     smp,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        overrun,
  output logic        underrun,
  output logic [5:0]  dbg_bit_cnt_o,
  output logic        dbg_pending_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam int PAD = 32 - SAMPLE_WIDTH;

  // Place a sample in a 32-bit slot: bit 31 is the I2S delay bit, the MSB
  // sits at bit 30, and the low bits are zero padding.
  function automatic logic [31:0] slot_word(input logic [SAMPLE_WIDTH-1:0] s);
    return {{PAD{1'b0}}, s} << (31 - SAMPLE_WIDTH);
  endfunction

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    bclk_q, bclk_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic                    pending_q, pending_d;
  logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d;
  logic [SAMPLE_WIDTH-1:0] frame_r_q, frame_r_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;

  logic        tick;
  logic        fall;
  logic        load;
  logic [31:0] slot;

  // Next-state logic: BCLK divider, bit counter, sample intake and serial bit.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    pending_d  = pending_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    slot       = '0;

    tick = (div_cnt_q == DIV_LAST);
    fall = tick && bclk_q;
    load = fall && (bit_cnt_q == 6'd63);

    if (tick) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
    end

    if (load) begin
      if (pending_q) begin
        // The older held sample goes out, and a coincident strobe refills the hold.
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        if (smp.sample_valid) begin
          hold_l_d  = smp.sample_l;
          hold_r_d  = smp.sample_r;
          pending_d = 1'b1;
        end else begin
          pending_d = 1'b0;
        end
      end else if (smp.sample_valid) begin
        // Bypass: the sample arrives exactly on the wrap with nothing queued.
        frame_l_d = smp.sample_l;
        frame_r_d = smp.sample_r;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        frame_l_d = '0;
        frame_r_d = '0;
`else
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
`endif
      end
    end else if (smp.sample_valid) begin
      // The newest sample wins. Replacing an unused one is an overrun.
      hold_l_d  = smp.sample_l;
      hold_r_d  = smp.sample_r;
      pending_d = 1'b1;
      overrun_d = pending_q;
    end

    if (fall) begin
      slot    = lrclk_d ? slot_word(frame_r_d) : slot_word(frame_l_d);
      sdata_d = slot[~bit_cnt_d[4:0]];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= 6'd63;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      pending_q  <= 1'b0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      pending_q  <= pending_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lrclk_q;
  assign i2s_sdata     = sdata_q;
  assign overrun       = overrun_q;
  assign underrun      = underrun_q;
  assign dbg_bit_cnt_o = bit_cnt_q;
  assign dbg_pending_o = pending_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed testbench for i2s_tx with BCLK_DIV=2 and SAMPLE_WIDTH=24.
// Expectations depend on I2S_TX_UNDERRUN_MUTE_EN in the same way as the design.
module tb_i2s_tx;
  localparam int SW  = 24;
  localparam int DIV = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) sif ();

  logic       i2s_bclk, i2s_lrclk, i2s_sdata, overrun, underrun;
  logic [5:0] dbg_bit_cnt;
  logic       dbg_pending;

  i2s_tx #(.SAMPLE_WIDTH(SW), .BCLK_DIV(DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .smp           (sif),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .overrun       (overrun),
    .underrun      (underrun),
    .dbg_bit_cnt_o (dbg_bit_cnt),
    .dbg_pending_o (dbg_pending)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;
  int glitch_cnt = 0;
  int cyc = 0;
  int lr_last = 0;
  int lr_period = 0;
  logic bclk_prev = 1'b0, sdata_prev = 1'b0, lrclk_prev = 1'b1, rst_prev = 1'b1;
  logic [2*SW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pin monitor: pulse counts, LRCLK period, and SDATA changing only with BCLK falls.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset && !rst_prev) begin
      if (i2s_sdata !== sdata_prev && !(bclk_prev && !i2s_bclk)) glitch_cnt <= glitch_cnt + 1;
      if (overrun)  ovr_cnt <= ovr_cnt + 1;
      if (underrun) und_cnt <= und_cnt + 1;
      if (lrclk_prev && !i2s_lrclk) begin
        lr_period <= cyc - lr_last;
        lr_last   <= cyc;
      end
    end
    bclk_prev  <= i2s_bclk;
    sdata_prev <= i2s_sdata;
    lrclk_prev <= i2s_lrclk;
    rst_prev   <= reset;
  end

  function automatic logic [63:0] exp_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  function automatic logic [SW-1:0] ramp_l(input int k);
    return SW'(k * 32'h010101 + 32'h000001);
  endfunction

  function automatic logic [SW-1:0] ramp_r(input int k);
    return ~ramp_l(k);
  endfunction

  // ---------------- driver tasks ----------------
  // Skip `skip` rising edges, then present a one-cycle strobe sampled on the next edge.
  task automatic strobe_at(input int skip, input logic [SW-1:0] l, input logic [SW-1:0] r);
    repeat (skip) @(posedge clk);
    #1;
    sif.sample_valid = 1'b1;
    sif.sample_l     = l;
    sif.sample_r     = r;
    @(posedge clk);
    #1;
    sif.sample_valid = 1'b0;
  endtask

  task automatic clear_counts();
    #1;
    ovr_cnt = 0;
    und_cnt = 0;
  endtask

  task automatic wait_lr_fall();
    logic pl;
    int   n;
    logic found;
    pl = i2s_lrclk;
    n = 0;
    found = 1'b0;
    while (!found && n < 600) begin
      @(negedge clk);
      n++;
      if (pl && !i2s_lrclk) found = 1'b1;
      pl = i2s_lrclk;
    end
    check("lr_fall_seen", 64'(found), 64'd1);
  endtask

  // Sample SDATA at the 64 BCLK rising edges that follow the frame start.
  task automatic capture_bits(output logic [63:0] raw);
    logic pb;
    int   k;
    int   n;
    raw = '0;
    pb = i2s_bclk;
    k = 0;
    n = 0;
    while (k < 64 && n < 400) begin
      @(negedge clk);
      n++;
      if (!pb && i2s_bclk) begin
        raw[63-k] = i2s_sdata;
        k++;
      end
      pb = i2s_bclk;
    end
    check("cap_bits", 64'(k), 64'd64);
  endtask

  task automatic get_frame(output logic [63:0] raw);
    wait_lr_fall();
    capture_bits(raw);
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] raw;
  logic [2*SW-1:0] e;

  initial begin
    reset = 1'b1;
    sif.sample_valid = 1'b0;
    sif.sample_l = '0;
    sif.sample_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bclk",    64'(i2s_bclk),    64'd0);
    check("rst_lrclk",   64'(i2s_lrclk),   64'd1);
    check("rst_sdata",   64'(i2s_sdata),   64'd0);
    check("rst_ovr",     64'(overrun),     64'd0);
    check("rst_und",     64'(underrun),    64'd0);
    check("rst_bitcnt",  64'(dbg_bit_cnt), 64'd63);
    check("rst_pending", 64'(dbg_pending), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_counts();

    // Single frame, strobed before the first wrap.
    strobe_at(0, 24'h800001, 24'h7FFFFE);
    get_frame(raw);
    check("single_frame", raw, exp_frame(24'h800001, 24'h7FFFFE));
    check("single_ovr", 64'(ovr_cnt), 64'd0);
    check("single_und", 64'(und_cnt), 64'd0);
    wait_lr_fall();
    #1;
    check("lr_period", 64'(lr_period), 64'd256);

    // Overrun: two strobes 10 cycles apart within one frame.
    clear_counts();
    strobe_at(5, 24'h000011, 24'h000011);
    strobe_at(9, 24'h000022, 24'h000022);
    @(negedge clk);
    check("ovr_pulse_hi", 64'(overrun), 64'd1);
    @(negedge clk);
    check("ovr_pulse_lo", 64'(overrun), 64'd0);
    get_frame(raw);
    check("ovr_frame", raw, exp_frame(24'h000022, 24'h000022));
    check("ovr_count", 64'(ovr_cnt), 64'd1);
    check("ovr_und", 64'(und_cnt), 64'd0);

    // Underrun after one good frame.
    wait_lr_fall();
    strobe_at(5, 24'h123456, 24'hABCDEF);
    get_frame(raw);
    check("und_src_frame", raw, exp_frame(24'h123456, 24'hABCDEF));
    clear_counts();
    get_frame(raw);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    check("und_frame", raw, exp_frame(24'h000000, 24'h000000));
`else
    check("und_frame", raw, exp_frame(24'h123456, 24'hABCDEF));
`endif
    check("und_count", 64'(und_cnt), 64'd1);

    // Strobe exactly on the wrap with nothing pending: bypass.
    wait_lr_fall();
    clear_counts();
    strobe_at(255, 24'h0000AA, 24'h0000AA);
    capture_bits(raw);
    check("bypass_frame", raw, exp_frame(24'h0000AA, 24'h0000AA));
    check("bypass_und", 64'(und_cnt), 64'd0);

    // Strobe on the wrap while 0xBB is pending: 0xBB goes out, 0xAA stays queued.
    wait_lr_fall();
    clear_counts();
    strobe_at(20, 24'h0000BB, 24'h0000BB);
    strobe_at(234, 24'h0000AA, 24'h0000AA);
    check("wrap_pending", 64'(dbg_pending), 64'd1);
    capture_bits(raw);
    check("wrap_frame", raw, exp_frame(24'h0000BB, 24'h0000BB));
    check("wrap_ovr", 64'(ovr_cnt), 64'd0);
    get_frame(raw);
    check("wrap_next_frame", raw, exp_frame(24'h0000AA, 24'h0000AA));
    check("wrap_und", 64'(und_cnt), 64'd0);

    // Reset at bit_cnt=40 with a sample pending.
    wait_lr_fall();
    strobe_at(10, 24'h5A5A5A, 24'hA5A5A5);
    repeat (150) @(posedge clk);
    #1;
    check("mid_bitcnt", 64'(dbg_bit_cnt), 64'd40);
    reset = 1'b1;
    #1;
    check("mid_rst_bclk",    64'(i2s_bclk),    64'd0);
    check("mid_rst_lrclk",   64'(i2s_lrclk),   64'd1);
    check("mid_rst_sdata",   64'(i2s_sdata),   64'd0);
    check("mid_rst_ovr",     64'(overrun),     64'd0);
    check("mid_rst_und",     64'(underrun),    64'd0);
    check("mid_rst_bitcnt",  64'(dbg_bit_cnt), 64'd63);
    check("mid_rst_pending", 64'(dbg_pending), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_counts();
    wait_lr_fall();
    check("restart_bitcnt", 64'(dbg_bit_cnt), 64'd0);
    capture_bits(raw);
    check("restart_frame", raw, exp_frame(24'h000000, 24'h000000));
    check("restart_und", 64'(und_cnt), 64'd1);

    // Rate match: one strobe per 256 clk over 100 frames.
    wait_lr_fall();
    clear_counts();
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          strobe_at((k == 0) ? 10 : 255, ramp_l(k), ramp_r(k));
          exp_q.push_back({ramp_l(k), ramp_r(k)});
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          get_frame(raw);
          if (exp_q.size() == 0) begin
            check("rate_sb_empty", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("rate_frame", raw, exp_frame(e[2*SW-1:SW], e[SW-1:0]));
          end
        end
      end
    join
    check("rate_ovr", 64'(ovr_cnt), 64'd0);
    check("rate_und", 64'(und_cnt), 64'd0);
    check("sdata_edges", 64'(glitch_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
